// File: rtl/mp3_play_ctrl_if.sv
// Volume command handshake between the playback scheduler and the SCI path.
// The master holds vol_cmd stable in meaning (newest volume) while valid is high.
interface mp3_play_ctrl_if;
   logic [31:0] vol_cmd;
   logic        vol_cmd_valid;
   logic        vol_cmd_ready;

   modport master (
      output vol_cmd,
      output vol_cmd_valid,
      input  vol_cmd_ready
   );

   modport slave (
      input  vol_cmd,
      input  vol_cmd_valid,
      output vol_cmd_ready
   );
endinterface

// File: rtl/mp3_play_ctrl.sv
// Playback scheduler for the VS1003 streaming path: track selection,
// streamer restart strobe and coalescing SCI volume command.
module mp3_play_ctrl #(
   parameter int         NUM_TRACKS  = 8,
   parameter int         RESTART_CYC = 300,
   parameter logic [7:0] VOL_STEP    = 8'h10,
   parameter logic [7:0] VOL_INIT    = 8'h80
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_play,
   input  logic        btn_next,
   input  logic        btn_prev,
   input  logic        vol_up,
   input  logic        vol_down,
   input  logic [1:0]  loop_mode,
   input  logic        track_done,
   output logic        start,
   output logic [2:0]  music_id,
   output logic        stream_restart,
   output logic [1:0]  state_dbg,
   mp3_play_ctrl_if.master vcmd
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PLAY   = 2'd1,
      S_PAUSE  = 2'd2,
      S_SWITCH = 2'd3
   } state_t;

   localparam int CW = (RESTART_CYC > 1) ? $clog2(RESTART_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(RESTART_CYC - 1);
   localparam logic [2:0]    ID_LAST  = 3'(NUM_TRACKS - 1);

   state_t        state_q, state_d;
   logic [2:0]    id_q, id_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    vol_q, vol_d;
   logic          valid_q, valid_d;

   logic       ev_next, ev_prev, ev_done, ev_play;
   logic [2:0] id_inc, id_dec;
   logic [7:0] vol_less, vol_more;

   // One event per cycle: next > prev > track_done > play.
   always_comb begin
      ev_next = btn_next;
      ev_prev = btn_prev & ~btn_next;
      ev_done = track_done & ~btn_next & ~btn_prev;
      ev_play = btn_play & ~btn_next & ~btn_prev & ~track_done;
   end

   always_comb begin
      id_inc = (id_q == ID_LAST) ? 3'd0 : id_q + 3'd1;
      id_dec = (id_q == 3'd0) ? ID_LAST : id_q - 3'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         id_q    <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (ev_next)
               id_d = id_inc;
            else if (ev_prev)
               id_d = id_dec;
            else if (ev_play)
               state_d = S_SWITCH;
         end
         S_SWITCH: begin
            if (ev_next | ev_prev) begin
               id_d  = ev_next ? id_inc : id_dec;
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_PLAY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_PLAY: begin
            cnt_d = '0;
            if (ev_next | ev_prev) begin
               id_d    = ev_next ? id_inc : id_dec;
               state_d = S_SWITCH;
            end else if (ev_done) begin
               unique case (loop_mode)
                  2'd0: state_d = S_IDLE;
                  2'd1: state_d = S_SWITCH;
                  default: begin
                     id_d    = id_inc;
                     state_d = S_SWITCH;
                  end
               endcase
            end else if (ev_play) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            cnt_d = '0;
            if (ev_next | ev_prev) begin
               id_d    = ev_next ? id_inc : id_dec;
               state_d = S_SWITCH;
            end else if (ev_play) begin
               state_d = S_PLAY;
            end
         end
      endcase
   end

   // Saturating attenuation steps; 0xFE is the quietest legal setting.
   always_comb begin
      vol_less = (vol_q < VOL_STEP) ? 8'h00 : vol_q - VOL_STEP;
      vol_more = (vol_q > 8'hFE - VOL_STEP) ? 8'hFE : vol_q + VOL_STEP;
   end

   always_comb begin
      vol_d = vol_q;
      if (vol_up & ~vol_down)
         vol_d = vol_less;
      else if (vol_down & ~vol_up)
         vol_d = vol_more;
   end

   // A fresh change wins over a completing handshake.
   always_comb begin
      valid_d = valid_q;
      if (vol_d != vol_q)
         valid_d = 1'b1;
      else if (valid_q & vcmd.vol_cmd_ready)
         valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vol_q   <= VOL_INIT;
         valid_q <= 1'b0;
      end else begin
         vol_q   <= vol_d;
         valid_q <= valid_d;
      end
   end

   assign start          = (state_q == S_PLAY);
   assign stream_restart = (state_q == S_IDLE) | (state_q == S_SWITCH);
   assign music_id       = id_q;
   assign state_dbg      = state_q;

   assign vcmd.vol_cmd       = {8'h02, 8'h0B, vol_q, vol_q};
   assign vcmd.vol_cmd_valid = valid_q;

endmodule

// File: doc/mp3_play_ctrl.md
Name: mp3_play_ctrl

Overview:
- Playback scheduler for the VS1003 MP3 streaming path.
- Turns user pulses (play/pause, next, prev, volume up/down) and the streamer's end-of-track pulse into three things:
  - the streamer's start enable and track select (music_id);
  - a restart strobe that re-initialises the streamer at each track change;
  - a 32-bit SCI volume command, handed over by valid/ready handshake.
- Sits between debounced board buttons and the mp3 streamer / SCI command path, on the 100 MHz system clock.

Parameters:
- NUM_TRACKS, 8, number of tracks stored in ROM; music_id wraps modulo NUM_TRACKS (2..8).
- RESTART_CYC, 300, system-clock cycles that stream_restart is held high. Must be ≥ 3 slow (1 MHz) streamer clock periods.
- VOL_STEP, 8'h10, attenuation change per volume pulse.
- VOL_INIT, 8'h80, attenuation loaded at reset (0x00 = loudest).

Ports:
- clk, input, 1, 100 MHz system clock.
- rst, input, 1, asynchronous active-high reset.
- btn_play, input, 1, one-cycle pulse; toggles play/pause.
- btn_next, input, 1, one-cycle pulse; select next track.
- btn_prev, input, 1, one-cycle pulse; select previous track.
- vol_up, input, 1, one-cycle pulse; reduce attenuation.
- vol_down, input, 1, one-cycle pulse; increase attenuation.
- loop_mode, input, 2, 0 = stop at end of track, 1 = repeat current track, 2/3 = advance with wrap.
- track_done, input, 1, one-cycle pulse from streamer when its ROM address wraps.
- start, output, 1, streamer enable; high only in PLAY.
- music_id, output, 3, current track index.
- stream_restart, output, 1, high = streamer held in reset.
- vol_cmd, output, 32, SCI write {8'h02, 8'h0B, vol, vol}.
- vol_cmd_valid, output, 1, vol_cmd is pending.
- vol_cmd_ready, input, 1, SCI path accepts vol_cmd.
- state_dbg, output, 2, encoded current state.

Behaviour:
- Reset values (async on rst high): state = IDLE, start = 0, music_id = 0, stream_restart = 1, vol = VOL_INIT, vol_cmd_valid = 0, restart counter = 0.
- States and state_dbg encoding: IDLE = 0, PLAY = 1, PAUSE = 2, SWITCH = 3.
- Event priority when pulses coincide in one cycle: btn_next > btn_prev > track_done > btn_play. Lower-priority pulses in that cycle are dropped.
- IDLE:
  - stream_restart = 1, start = 0.
  - btn_play → SWITCH (music_id unchanged).
  - btn_next / btn_prev → change music_id, stay IDLE.
- SWITCH:
  - stream_restart = 1; counter counts 0..RESTART_CYC-1.
  - At count RESTART_CYC-1: go to PLAY, stream_restart = 0 the next cycle, counter cleared.
  - btn_next / btn_prev in SWITCH: update music_id and restart the counter from 0.
  - All other pulses in SWITCH are ignored.
- PLAY:
  - start = 1, stream_restart = 0.
  - btn_play → PAUSE.
  - btn_next / btn_prev → update music_id, go to SWITCH.
  - track_done, by loop_mode:
    - 0 → IDLE;
    - 1 → SWITCH, same music_id;
    - 2/3 → music_id + 1 (wrapped), SWITCH.
- PAUSE:
  - start = 0, stream_restart = 0 (streamer state preserved).
  - btn_play → PLAY.
  - btn_next / btn_prev → update music_id, go to SWITCH.
  - track_done is ignored.
- Track arithmetic:
  - next: music_id == NUM_TRACKS-1 → 0, else +1.
  - prev: music_id == 0 → NUM_TRACKS-1, else -1.
- Volume (independent of the state machine; processed in every state):
  - vol_up: vol = (vol < VOL_STEP) ? 0 : vol - VOL_STEP.
  - vol_down: vol = (vol > 8'hFE - VOL_STEP) ? 8'hFE : vol + VOL_STEP.
  - vol_up and vol_down in the same cycle: both ignored.
  - Any change that actually alters vol sets vol_cmd_valid = 1. A pulse that leaves vol saturated and unchanged does not.
  - vol_cmd is combinational from the current vol, so it always reflects the newest value.
  - Handshake: vol_cmd_valid clears on the cycle after valid & ready. If vol changes in that same cycle, valid stays 1.
  - While valid is high, vol may keep changing (coalescing); only the latest vol is sent.
  - valid must not drop without ready unless rst is asserted.
  - After reset, no command is issued until the first volume change.
- Latency: every state or output change takes effect one clock after the causing pulse.

Test Plan:
- Reset, then btn_play → IDLE→SWITCH; stream_restart stays 1 for exactly 300 cycles; then start = 1, state_dbg = 1, music_id = 0.
- In PLAY with music_id = 7: btn_next → music_id = 0, SWITCH; btn_prev at music_id = 0 → 7.
- track_done in PLAY:
  - loop_mode 0 → IDLE, start = 0;
  - loop_mode 1 → SWITCH, music_id unchanged;
  - loop_mode 2 with id 3 → id 4, back in PLAY after 300 cycles.
- btn_next and btn_play in the same cycle during PLAY → next wins: music_id + 1, SWITCH, no PAUSE. btn_play in PAUSE → PLAY, with no restart strobe.
- Volume:
  - From 8'h80, vol_up ×9 → vol = 0x00, saturates.
  - vol_down at 0xF8 → 0xFE.
  - vol_cmd = 32'h020B1010 after reaching vol 0x10.
  - With ready held low, three ups → single pending command carrying the final value; valid clears one cycle after ready.
- rst asserted mid-SWITCH → all outputs return to reset values immediately (asynchronously); a subsequent btn_play restarts the sequence cleanly.
